// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block-transfer channel among NDRV drives.
// A grant is held from request through ack completion, or until the ack timeout fires.
module iecdrv_sd_arbiter #(
  parameter int          NDRV        = 4,
  parameter logic [23:0] ACK_TIMEOUT = 24'd8_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NDRV*32-1:0] drv_lba,
  input  logic [NDRV*6-1:0]  drv_blk_cnt,
  input  logic [NDRV-1:0]    drv_rd,
  input  logic [NDRV-1:0]    drv_wr,
  output logic [NDRV-1:0]    drv_ack,
  input  logic [NDRV*8-1:0]  drv_buff_din,
  output logic [31:0]        sd_lba,
  output logic [5:0]         sd_blk_cnt,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  output logic [7:0]         sd_buff_din,
  output logic               grant_valid,
  output logic [1:0]         grant_idx,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt, grant_idx_nxt;
  logic [31:0] sd_lba_nxt;
  logic [5:0]  sd_blk_cnt_nxt;
  logic        sd_rd_nxt, sd_wr_nxt, grant_valid_nxt, timeout_err_nxt;
  logic [23:0] tcnt, tcnt_nxt;

  logic        found;
  logic [1:0]  win_idx;
  logic        win_wr;
  logic [31:0] win_lba;
  logic [5:0]  win_cnt;

  // Rotating scan: the outer loop walks priority order starting at ptr.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_wr  = 1'b0;
    win_lba = '0;
    win_cnt = '0;
    for (int k = 0; k < NDRV; k++) begin
      for (int i = 0; i < NDRV; i++) begin
        if (!found && (drv_rd[i] || drv_wr[i]) && ((int'(ptr) + k) % NDRV) == i) begin
          found   = 1'b1;
          win_idx = 2'(i);
          win_wr  = drv_wr[i];
          win_lba = drv_lba[32*i +: 32];
          win_cnt = drv_blk_cnt[6*i +: 6];
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    grant_idx_nxt   = grant_idx;
    sd_lba_nxt      = sd_lba;
    sd_blk_cnt_nxt  = sd_blk_cnt;
    sd_rd_nxt       = sd_rd;
    sd_wr_nxt       = sd_wr;
    grant_valid_nxt = grant_valid;
    timeout_err_nxt = 1'b0;
    tcnt_nxt        = tcnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_idx_nxt   = win_idx;
          sd_lba_nxt      = win_lba;
          sd_blk_cnt_nxt  = win_cnt;
          sd_wr_nxt       = win_wr;
          sd_rd_nxt       = !win_wr;
          grant_valid_nxt = 1'b1;
          tcnt_nxt        = '0;
          state_nxt       = REQ;
        end
      end
      REQ: begin
        tcnt_nxt = tcnt + 24'd1;
        if (sd_ack) begin
          sd_rd_nxt = 1'b0;
          sd_wr_nxt = 1'b0;
          state_nxt = XFER;
        end else if (ACK_TIMEOUT != 24'd0 && tcnt_nxt == ACK_TIMEOUT) begin
          sd_rd_nxt       = 1'b0;
          sd_wr_nxt       = 1'b0;
          timeout_err_nxt = 1'b1;
          grant_valid_nxt = 1'b0;
          state_nxt       = DONE;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          grant_valid_nxt = 1'b0;
          state_nxt       = DONE;
        end
      end
      DONE: begin
        ptr_nxt   = (grant_idx == 2'(NDRV - 1)) ? 2'd0 : grant_idx + 2'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      sd_lba      <= '0;
      sd_blk_cnt  <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      grant_valid <= 1'b0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_idx   <= grant_idx_nxt;
      sd_lba      <= sd_lba_nxt;
      sd_blk_cnt  <= sd_blk_cnt_nxt;
      sd_rd       <= sd_rd_nxt;
      sd_wr       <= sd_wr_nxt;
      grant_valid <= grant_valid_nxt;
      timeout_err <= timeout_err_nxt;
      tcnt        <= tcnt_nxt;
    end
  end

  // Host ack and write data only ever reach the owning drive.
  always_comb begin
    drv_ack     = '0;
    sd_buff_din = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (grant_valid && grant_idx == 2'(i)) begin
        drv_ack[i]  = sd_ack;
        sd_buff_din = drv_buff_din[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Directed bench for iecdrv_sd_arbiter: single read, round-robin, rd+wr, timeout, reset, latching.
module tb_iecdrv_sd_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*32-1:0] drv_lba;
  logic [N*6-1:0]  drv_blk_cnt;
  logic [N-1:0]    drv_rd, drv_wr, drv_ack;
  logic [N*8-1:0]  drv_buff_din;
  logic [31:0]     sd_lba;
  logic [5:0]      sd_blk_cnt;
  logic            sd_rd, sd_wr, sd_ack;
  logic [7:0]      sd_buff_din;
  logic            grant_valid, timeout_err;
  logic [1:0]      grant_idx;

  int errors = 0;
  int checks = 0;

  iecdrv_sd_arbiter #(.NDRV(N), .ACK_TIMEOUT(24'd16)) dut (
    .clk(clk), .reset(reset), .drv_lba(drv_lba), .drv_blk_cnt(drv_blk_cnt),
    .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_ack(drv_ack), .drv_buff_din(drv_buff_din),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant, acks it for two cycles, drops the served op, and returns in IDLE.
  task automatic serve(output logic [1:0] got, output bit seen, output bit was_wr,
                       output logic [7:0] data);
    seen = 1'b0; got = '0; was_wr = 1'b0; data = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (sd_rd || sd_wr) seen = 1'b1;
      else step();
    end
    if (seen) begin
      got = grant_idx; was_wr = sd_wr; data = sd_buff_din;
      sd_ack = 1'b1;
      step();
      if (was_wr) drv_wr[got] = 1'b0;
      else drv_rd[got] = 1'b0;
      step();
      sd_ack = 1'b0;
      step();
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin errors++; $display("FAIL reset_req: rd=%b wr=%b want 0 0", sd_rd, sd_wr); end
    checks++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_flags: gv=%b to=%b want 0 0", grant_valid, timeout_err); end
    checks++; if (drv_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: %b want 0000", drv_ack); end
    checks++; if (sd_lba !== 32'd0 || sd_blk_cnt !== 6'd0 || grant_idx !== 2'd0) begin errors++; $display("FAIL reset_regs: lba=%h cnt=%0d idx=%0d want 0", sd_lba, sd_blk_cnt, grant_idx); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    bit ack_ok = 1'b1;
    drv_rd[2] = 1'b1;
    drv_lba[64 +: 32] = 32'h123;
    drv_blk_cnt[12 +: 6] = 6'd5;
    step();
    checks++; if (sd_rd !== 1'b1 || sd_wr !== 1'b0) begin errors++; $display("FAIL single_req: rd=%b wr=%b want 1 0", sd_rd, sd_wr); end
    checks++; if (sd_lba !== 32'h123 || sd_blk_cnt !== 6'd5) begin errors++; $display("FAIL single_fwd: lba=%h cnt=%0d want 123 5", sd_lba, sd_blk_cnt); end
    checks++; if (grant_valid !== 1'b1 || grant_idx !== 2'd2) begin errors++; $display("FAIL single_grant: gv=%b idx=%0d want 1 2", grant_valid, grant_idx); end
    step();
    sd_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (drv_ack !== 4'b0100) ack_ok = 1'b0;
      if (c == 0) drv_rd[2] = 1'b0;
    end
    checks++; if (!ack_ok) begin errors++; $display("FAIL single_ack: drv_ack not 0100 throughout ack, last=%b", drv_ack); end
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL single_drop: rd=%b want 0", sd_rd); end
    sd_ack = 1'b0;
    step();
    checks++; if (grant_valid !== 1'b0 || drv_ack !== 4'b0) begin errors++; $display("FAIL single_release: gv=%b ack=%b want 0 0000", grant_valid, drv_ack); end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] got; bit seen, wr; logic [7:0] d;
    logic [1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    reset = 1'b1;
    drv_rd = 4'hF;
    for (int i = 0; i < N; i++) drv_lba[32*i +: 32] = 32'h100 + 32'(i);
    step();
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) begin drv_rd[0] = 1'b1; drv_rd[3] = 1'b1; end
      serve(got, seen, wr, d);
      checks++; if (!seen || got !== exp_seq[n]) begin errors++; $display("FAIL rr_order%0d: seen=%b idx=%0d want %0d", n, seen, got, exp_seq[n]); end
    end
  endtask

  task automatic test_rd_wr();
    logic [1:0] got; bit seen, wr; logic [7:0] d;
    drv_buff_din = 32'h44_33_22_11;
    drv_rd[1] = 1'b1; drv_wr[1] = 1'b1; drv_rd[2] = 1'b1;
    serve(got, seen, wr, d);
    checks++; if (!seen || got !== 2'd1 || wr !== 1'b1) begin errors++; $display("FAIL rdwr_first: idx=%0d wr=%b want 1 1", got, wr); end
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL rdwr_data: din=%h want 22", d); end
    serve(got, seen, wr, d);
    checks++; if (!seen || got !== 2'd2 || wr !== 1'b0) begin errors++; $display("FAIL rdwr_second: idx=%0d wr=%b want 2 0", got, wr); end
    serve(got, seen, wr, d);
    checks++; if (!seen || got !== 2'd1 || wr !== 1'b0) begin errors++; $display("FAIL rdwr_read: idx=%0d wr=%b want 1 0", got, wr); end
  endtask

  task automatic test_timeout();
    int hi = 0;
    logic [1:0] got; bit seen, wr; logic [7:0] d;
    drv_rd[3] = 1'b1; drv_rd[0] = 1'b1;
    step();
    for (int c = 0; c < 40; c++) begin
      if (!sd_rd) break;
      hi++;
      step();
    end
    checks++; if (hi != 16) begin errors++; $display("FAIL to_len: rd high %0d cycles want 16", hi); end
    checks++; if (timeout_err !== 1'b1 || grant_idx !== 2'd3) begin errors++; $display("FAIL to_pulse: to=%b idx=%0d want 1 3", timeout_err, grant_idx); end
    drv_rd[3] = 1'b0;
    step();
    checks++; if (timeout_err !== 1'b0 || grant_valid !== 1'b0) begin errors++; $display("FAIL to_done: to=%b gv=%b want 0 0", timeout_err, grant_valid); end
    step();
    checks++; if (sd_rd !== 1'b1 || grant_idx !== 2'd0) begin errors++; $display("FAIL to_next: rd=%b idx=%0d want 1 0", sd_rd, grant_idx); end
    serve(got, seen, wr, d);
  endtask

  task automatic test_reset_mid_xfer();
    logic [1:0] got; bit seen, wr; logic [7:0] d;
    drv_rd[2] = 1'b1;
    step();
    sd_ack = 1'b1;
    step();
    checks++; if (drv_ack !== 4'b0100) begin errors++; $display("FAIL rst_pre: ack=%b want 0100", drv_ack); end
    reset = 1'b1;
    step();
    checks++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || grant_valid !== 1'b0) begin errors++; $display("FAIL rst_mid: rd=%b wr=%b gv=%b want 0 0 0", sd_rd, sd_wr, grant_valid); end
    checks++; if (drv_ack !== 4'b0) begin errors++; $display("FAIL rst_ack: ack=%b want 0000", drv_ack); end
    sd_ack = 1'b0; drv_rd[2] = 1'b0;
    drv_rd[0] = 1'b1; drv_rd[3] = 1'b1;
    reset = 1'b0;
    serve(got, seen, wr, d);
    checks++; if (!seen || got !== 2'd0) begin errors++; $display("FAIL rst_ptr: idx=%0d want 0", got); end
    serve(got, seen, wr, d);
  endtask

  task automatic test_latch();
    bit stable = 1'b1;
    drv_lba[0 +: 32] = 32'd7;
    drv_rd[0] = 1'b1;
    step();
    checks++; if (sd_lba !== 32'd7 || grant_idx !== 2'd0) begin errors++; $display("FAIL latch_init: lba=%0d idx=%0d want 7 0", sd_lba, grant_idx); end
    drv_lba[0 +: 32] = 32'd9;
    drv_rd[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (sd_lba !== 32'd7) stable = 1'b0;
    end
    checks++; if (sd_rd !== 1'b1) begin errors++; $display("FAIL latch_commit: rd=%b want 1", sd_rd); end
    sd_ack = 1'b1;
    step();
    if (sd_lba !== 32'd7) stable = 1'b0;
    sd_ack = 1'b0;
    step();
    checks++; if (!stable || sd_lba !== 32'd7) begin errors++; $display("FAIL latch_stable: lba=%0d want 7", sd_lba); end
    step();
  endtask

  initial begin
    reset = 1'b1; sd_ack = 1'b0;
    drv_lba = '0; drv_blk_cnt = '0; drv_rd = '0; drv_wr = '0; drv_buff_din = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_rd_wr();
    test_timeout();
    test_reset_mid_xfer();
    test_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iecdrv_sd_arbiter.md
Name: iecdrv_sd_arbiter

Overview:
- Shares the single host SD block-transfer channel among NDRV IEC drive instances.
- Each drive presents a level request (rd or wr, lba, blk_cnt) exactly as it would to the host.
- The arbiter grants one drive at a time in round-robin order, forwards its request, routes the host ack and write-data back to it, and releases on ack completion.
- Sits between the per-drive track loaders and the top-level SD interface.

Parameters:
- NDRV, 4, number of drives sharing the channel (1..4).
- ACK_TIMEOUT, 24'd8_000_000, clk cycles to wait for sd_ack rise before aborting a grant; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- drv_lba  in  NDRV*32  per-drive LBA; drive i occupies bits [32i+31:32i]
- drv_blk_cnt  in  NDRV*6  per-drive block count minus one
- drv_rd  in  NDRV  per-drive read request, held until the drive sees its ack
- drv_wr  in  NDRV  per-drive write request, held until the drive sees its ack
- drv_ack  out  NDRV  per-drive ack; only the granted bit follows sd_ack
- drv_buff_din  in  NDRV*8  per-drive write data toward SD
- sd_lba  out  32  forwarded LBA
- sd_blk_cnt  out  6  forwarded block count
- sd_rd  out  1  forwarded read request
- sd_wr  out  1  forwarded write request
- sd_ack  in  1  host ack
- sd_buff_din  out  8  write data from the granted drive
- grant_valid  out  1  a drive currently owns the channel
- grant_idx  out  2  index of the owning drive
- timeout_err  out  1  one-cycle pulse when a grant is aborted

Behaviour:
- States: IDLE, REQ, XFER, DONE.
- Reset values:
  - state IDLE; rr pointer 0 (drive 0 scanned first).
  - sd_rd, sd_wr, grant_valid, timeout_err = 0; drv_ack = 0.
  - sd_lba = 0, sd_blk_cnt = 0, grant_idx = 0; timeout counter 0.
  - Reset asserted mid-transfer forces all of the above on the next edge; the host sees sd_rd/sd_wr drop.
- IDLE:
  - Pending for drive i = drv_rd[i] | drv_wr[i].
  - Scan order is ptr, ptr+1, … mod NDRV; the first pending drive wins.
  - On the winning edge, register grant_idx, its lba and blk_cnt, and op; then go to REQ with grant_valid=1.
  - Op selection: wr has priority over rd when the same drive asserts both.
  - Request-to-sd_rd/sd_wr latency is 1 clk.
- REQ:
  - sd_rd or sd_wr (per latched op) is held high; sd_lba and sd_blk_cnt are stable at their latched values.
  - On sd_ack=1, drop sd_rd/sd_wr on the same edge and go to XFER.
  - The counter increments each cycle. If ACK_TIMEOUT≠0 and count reaches ACK_TIMEOUT: drop request, pulse timeout_err, go to DONE.
- XFER: wait for sd_ack=0, then go to DONE.
- DONE:
  - One cycle; grant_valid=0; ptr = grant_idx+1 mod NDRV; go to IDLE.
  - The earliest next grant is therefore 2 cycles after ack falls.
- Ack and data routing (combinational):
  - drv_ack[i] = sd_ack & grant_valid & (grant_idx==i).
  - sd_buff_din = drv_buff_din[grant_idx] while grant_valid, else 0.
  - Host sd_buff_addr, sd_buff_dout and sd_buff_wr are broadcast externally; drives gate them with their own drv_ack.
- Commitment: once granted, the request is committed. Deassertion of the drive's rd/wr before sd_ack is ignored. Input changes to lba/blk_cnt after latch are ignored.
- Same-drive rd+wr: the write is served first. The read remains pending and is served in a later arbitration, after the other pending drives ahead of it in rotation.
- NDRV=1: ptr stays 0; behaviour is otherwise identical.
- An sd_ack already high on entry to REQ counts as the ack.

Test Plan:
- Single read: drive 2 rd=1, lba=0x123, cnt=5 → sd_rd=1 one clk later with sd_lba=0x123, sd_blk_cnt=5; sd_ack 1 for 10 clk → drv_ack[2] high those 10 clk, others 0; grant_valid clears 1 clk after ack falls.
- Round-robin: all four drives request rd at reset release → grants in order 0,1,2,3. Then re-request drives 0 and 3 → order 0,3 (ptr=0 after drive 3).
- Same-drive rd+wr: drive 1 asserts both → sd_wr first; sd_buff_din equals drv_buff_din[15:8]; after completion the read is issued as a separate grant.
- Timeout: ACK_TIMEOUT=16, no ack → sd_rd high exactly 16 clk, timeout_err one-cycle pulse, next pending drive granted 2 clk later.
- Reset mid-XFER: reset during sd_ack=1 → next edge sd_rd=sd_wr=0, grant_valid=0, drv_ack all 0, ptr=0.
- Latch stability: drive 0 changes drv_lba from 7 to 9 during REQ → sd_lba stays 7 until DONE.
